// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues sequential ICCM word reads and buffers
// responses in an in-order prefetch FIFO. Optional same-cycle bypass: IFU_FETCH_BYPASS_EN.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PC_WIDTH   = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  cntlr_rd,
    output logic [ADDR_WIDTH-1:0] cntlr_raddr,
    input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
    input  logic                  cntlr_rd_valid,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  inst_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]   fetch_pc, resp_pc;
    logic [CW-1:0]         outstanding, drop, count, out_next;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PC_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
    logic [CW:0]           credit_used;
    logic                  issue, keep, push, fifo_pop, fifo_nonempty;
    logic [PC_WIDTH-1:0]   redirect_base;
    logic                  unused_redirect_lsb;

    assign redirect_base       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding reads reserve FIFO slots, so a response always has room.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign issue       = rst_n && !redirect && (credit_used < DEPTH_C);
    assign cntlr_rd    = issue;
    assign cntlr_raddr = fetch_pc[ADDR_WIDTH+1:2];

    assign keep          = cntlr_rd_valid && (drop == '0) && !redirect;
    assign fifo_nonempty = (count != '0);
    assign fifo_pop      = fifo_nonempty && inst_ready;
    assign out_next      = outstanding + CW'(issue) - CW'(cntlr_rd_valid);

`ifdef IFU_FETCH_BYPASS_EN
    logic bypass;
    // Only an empty FIFO exposes the response; otherwise the head takes priority.
    assign bypass     = keep && !fifo_nonempty;
    assign push       = keep && !(bypass && inst_ready);
    assign inst_valid = fifo_nonempty || bypass;
    assign inst       = fifo_nonempty ? fifo_inst[rd_ptr] : (bypass ? cntlr_rd_data : '0);
    assign inst_pc    = fifo_nonempty ? fifo_pc[rd_ptr]   : (bypass ? resp_pc       : '0);
`else
    assign push       = keep;
    assign inst_valid = fifo_nonempty;
    assign inst       = fifo_nonempty ? fifo_inst[rd_ptr] : '0;
    assign inst_pc    = fifo_nonempty ? fifo_pc[rd_ptr]   : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Everything still in flight belongs to the old stream.
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                drop     <= out_next;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + PC_WIDTH'(4);
                if (keep)
                    resp_pc <= resp_pc + PC_WIDTH'(4);
                if (cntlr_rd_valid && (drop != '0))
                    drop <= drop - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (fifo_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !redirect && push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= cntlr_rd_data;
        end
    end
endmodule
